// File: rtl/arb2_mux64_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb2_pkg
// Purpose  : Shared types and helpers for the two-source round-robin
//            arbiter / 64-bit mux sequencer (arb2_mux64_ctrl).
//            - state_t : FSM state encoding (IDLE, GRANT0, GRANT1)
//            - cnt_width() : beat counter width for a given MAX_BURST
// Revision : 1.0  initial release
// ============================================================================
package arb2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        GRANT0 = ST_GRANT0,
        GRANT1 = ST_GRANT1
    } state_t;

    // Counter must hold values 0..MAX_BURST inclusive.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage : arb2_pkg
`default_nettype wire

// File: rtl/arb2_mux64_ctrl_mux.sv
`default_nettype none
// ============================================================================
// Module   : mux2t1_64
// Purpose  : Plain 2:1 data mux selecting between the two source buses.
// Ports    : sel (0 = a, 1 = b), a, b : WIDTH-bit inputs, y : WIDTH-bit output
// Revision : 1.0  initial release
// ============================================================================
module mux2t1_64 #(
    parameter int WIDTH = 64
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule : mux2t1_64
`default_nettype wire

// File: rtl/arb2_mux64_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arb2_mux64_ctrl
// Purpose  : Round-robin arbiter and sequencer for a shared 64-bit 2:1 mux.
//            Grants bursts of up to MAX_BURST beats to src0/src1 and registers
//            each accepted beat into a one-entry valid/ready output buffer.
// Ports    : clk, rst_n (async active-low)
//            s0_valid/s0_data/s0_last -> s0_ready   source 0 beat interface
//            s1_valid/s1_data/s1_last -> s1_ready   source 1 beat interface
//            m_valid/m_data/m_src/m_last <- m_ready downstream buffer output
//            sel  : registered mux select, busy : high while a grant is open
// Revision : 1.0  initial release
// ============================================================================
module arb2_mux64_ctrl
    import arb2_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int MAX_BURST = 4,
    parameter bit RR_INIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s0_valid,
    input  logic [WIDTH-1:0] s0_data,
    input  logic             s0_last,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [WIDTH-1:0] s1_data,
    input  logic             s1_last,
    output logic             s1_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_src,
    output logic             m_last,
    input  logic             m_ready,
    output logic             sel,
    output logic             busy
);

    localparam int              CNT_W    = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [WIDTH-1:0] mux_data;

    logic grant_src;   // source owning the current grant
    logic cur_valid;
    logic cur_last;
    logic slot_free;   // buffer empty or draining this cycle
    logic accept;
    logic beat_last;
    logic win;

    mux2t1_64 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (sel),
        .a   (s0_data),
        .b   (s1_data),
        .y   (mux_data)
    );

    assign grant_src = (state == GRANT1);
    assign cur_valid = grant_src ? s1_valid : s0_valid;
    assign cur_last  = grant_src ? s1_last  : s0_last;
    assign slot_free = !m_valid || m_ready;
    assign accept    = (state != IDLE) && cur_valid && slot_free;
    assign beat_last = cur_last || (beat_cnt == LAST_CNT);
    // Pointer only matters on a tie; otherwise the lone requester wins.
    assign win       = (s0_valid && s1_valid) ? rr_ptr : s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    state_nxt = win ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                busy     = 1'b1;
                s0_ready = slot_free;
                if (accept && beat_last) begin
                    state_nxt = IDLE;
                end
            end
            GRANT1: begin
                busy     = 1'b1;
                s1_ready = slot_free;
                if (accept && beat_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Arbitration bookkeeping and the one-entry output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= RR_INIT;
            sel      <= 1'b0;
            beat_cnt <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_src    <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            if (state == IDLE && (s0_valid || s1_valid)) begin
                sel      <= win;
                beat_cnt <= '0;
            end
            if (accept) begin
                // A new beat replaces a draining one, giving 1 beat/clk.
                m_valid  <= 1'b1;
                m_data   <= mux_data;
                m_src    <= grant_src;
                m_last   <= beat_last;
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_last) begin
                    rr_ptr <= ~grant_src;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule : arb2_mux64_ctrl
`default_nettype wire

// File: tb/tb_arb2_mux64_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb2_mux64_ctrl
// Purpose  : Self-checking bench for arb2_mux64_ctrl. Sources are modelled as
//            beat queues; a transaction-level reference (grant owner, beats
//            sent in grant, buffered beat) predicts every output each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_arb2_mux64_ctrl;

    localparam int WIDTH     = 64;
    localparam int MAX_BURST = 4;
    localparam bit RR_INIT   = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s0_valid, s0_last, s0_ready;
    logic             s1_valid, s1_last, s1_ready;
    logic [WIDTH-1:0] s0_data, s1_data, m_data;
    logic             m_valid, m_src, m_last, m_ready, sel, busy;

    always #5 clk = ~clk;

    arb2_mux64_ctrl #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST),
        .RR_INIT   (RR_INIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_src    (m_src),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .sel      (sel),
        .busy     (busy)
    );

    typedef struct {
        logic [63:0] data;
        bit          last;
    } beat_t;

    beat_t       q0[$];
    beat_t       q1[$];
    logic [63:0] dut_log[$];
    logic [63:0] exp_q[$];
    bit          en0, en1, mr;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference state: who owns the channel, beats sent in this grant,
    // round-robin favourite and the contents of the output buffer.
    int          md_owner;
    int          md_cnt;
    bit          md_rr, md_sel;
    bit          mb_valid, mb_src, mb_last;
    logic [63:0] mb_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_owner = -1;
        md_cnt   = 0;
        md_rr    = RR_INIT;
        md_sel   = 1'b0;
        mb_valid = 1'b0;
        mb_data  = '0;
        mb_src   = 1'b0;
        mb_last  = 1'b0;
    endtask

    task automatic push(input int src, input logic [63:0] d, input bit l);
        beat_t b;
        b.data = d;
        b.last = l;
        if (src == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    // One clock: entered at a falling edge, drives inputs, checks outputs,
    // advances the reference, returns at the next falling edge.
    task automatic cycle();
        bit    v0, v1, rdy0, rdy1, acc, lst;
        beat_t b;
        v0       = en0 && (q0.size() > 0);
        v1       = en1 && (q1.size() > 0);
        s0_valid = v0;
        s0_data  = v0 ? q0[0].data : '0;
        s0_last  = v0 ? q0[0].last : 1'b0;
        s1_valid = v1;
        s1_data  = v1 ? q1[0].data : '0;
        s1_last  = v1 ? q1[0].last : 1'b0;
        m_ready  = mr;
        #1;
        rdy0 = (md_owner == 0) && (!mb_valid || mr);
        rdy1 = (md_owner == 1) && (!mb_valid || mr);
        chk("s0_ready", 64'(s0_ready), 64'(rdy0));
        chk("s1_ready", 64'(s1_ready), 64'(rdy1));
        chk("busy",     64'(busy),     64'(md_owner >= 0));
        chk("sel",      64'(sel),      64'(md_sel));
        chk("m_valid",  64'(m_valid),  64'(mb_valid));
        chk("m_data",   m_data,        mb_data);
        chk("m_src",    64'(m_src),    64'(mb_src));
        chk("m_last",   64'(m_last),   64'(mb_last));
        if (m_valid && m_ready) dut_log.push_back(m_data);

        acc = 1'b0;
        if (md_owner < 0) begin
            if (v0 || v1) begin
                md_owner = (v0 && v1) ? (md_rr ? 1 : 0) : (v1 ? 1 : 0);
                md_sel   = (md_owner == 1);
                md_cnt   = 0;
            end
            if (mb_valid && mr) mb_valid = 1'b0;
        end else begin
            if (md_owner == 0 && v0 && rdy0) begin b = q0.pop_front(); acc = 1'b1; end
            if (md_owner == 1 && v1 && rdy1) begin b = q1.pop_front(); acc = 1'b1; end
            if (acc) begin
                md_cnt++;
                lst      = b.last || (md_cnt == MAX_BURST);
                mb_valid = 1'b1;
                mb_data  = b.data;
                mb_src   = (md_owner == 1);
                mb_last  = lst;
                if (lst) begin
                    md_rr    = (md_owner == 0);
                    md_owner = -1;
                end
            end else if (mb_valid && mr) begin
                mb_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Asynchronous reset pulse away from any clock edge; outputs must clear
    // before the next rising edge.
    task automatic do_reset();
        #2;
        rst_n    = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        en0      = 1'b0;
        en1      = 1'b0;
        #1;
        chk("rst_m_valid",  64'(m_valid),  64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_sel",      64'(sel),      64'd0);
        chk("rst_s0_ready", 64'(s0_ready), 64'd0);
        chk("rst_s1_ready", 64'(s1_ready), 64'd0);
        chk("rst_m_data",   m_data,        64'd0);
        chk("rst_m_last",   64'(m_last),   64'd0);
        chk("rst_m_src",    64'(m_src),    64'd0);
        model_reset();
        q0.delete();
        q1.delete();
        dut_log.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 64'(dut_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i),
                (i < dut_log.size()) ? dut_log[i] : 64'hx, exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
        m_ready  = 1'b0;
        en0 = 1'b0; en1 = 1'b0; mr = 1'b1;
        model_reset();
        @(negedge clk);

        // Single source, 3-beat burst at full throughput.
        do_reset();
        push(0, 64'hA0, 0); push(0, 64'hA1, 0); push(0, 64'hA2, 1);
        en0 = 1'b1; mr = 1'b1;
        run(7);
        exp_q = '{64'hA0, 64'hA1, 64'hA2};
        check_log("t1");

        // Both sources busy with 1-beat bursts: grants alternate.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 64'hB0 + 64'(i), 1);
            push(1, 64'hC0 + 64'(i), 1);
        end
        en0 = 1'b1; en1 = 1'b1;
        run(20);
        exp_q = '{64'hB0, 64'hC0, 64'hB1, 64'hC1, 64'hB2, 64'hC2, 64'hB3, 64'hC3};
        check_log("t2");

        // Burst cap forces re-arbitration, s1 resumes afterwards.
        do_reset();
        for (int i = 0; i < 6; i++) push(1, 64'h90 + 64'(i), 0);
        en1 = 1'b1;
        run(1);
        push(0, 64'h80, 1);
        en0 = 1'b1;
        run(14);
        exp_q = '{64'h90, 64'h91, 64'h92, 64'h93, 64'h80, 64'h94, 64'h95};
        check_log("t3");

        // Downstream stall mid-burst.
        do_reset();
        for (int i = 0; i < 4; i++) push(0, 64'hD0 + 64'(i), i == 3);
        en0 = 1'b1; mr = 1'b1;
        run(3);
        mr = 1'b0;
        run(5);
        mr = 1'b1;
        run(6);
        exp_q = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
        check_log("t4");

        // Owner drops valid mid-burst; grant held, s1 waits.
        do_reset();
        push(0, 64'hE0, 0); push(0, 64'hE1, 0); push(0, 64'hE2, 1);
        en0 = 1'b1;
        run(2);
        en0 = 1'b0;
        push(1, 64'hF0, 1);
        en1 = 1'b1;
        run(3);
        en0 = 1'b1;
        run(8);
        exp_q = '{64'hE0, 64'hE1, 64'hE2, 64'hF0};
        check_log("t6");

        // Reset during beat 2 while the pointer favours s1.
        do_reset();
        push(0, 64'h50, 1);
        en0 = 1'b1;
        run(3);
        for (int i = 0; i < 4; i++) push(1, 64'h60 + 64'(i), i == 3);
        en1 = 1'b1;
        run(3);
        do_reset();
        push(0, 64'h70, 1); push(1, 64'h71, 1);
        en0 = 1'b1; en1 = 1'b1;
        run(6);
        exp_q = '{64'h70, 64'h71};
        check_log("t5");

        // Randomised traffic against the reference.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en0 = ($urandom_range(0, 9) < 8);
            en1 = ($urandom_range(0, 9) < 8);
            mr  = ($urandom_range(0, 3) != 0);
            if (q0.size() < 3) push(0, {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
            if (q1.size() < 3) push(1, {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_arb2_mux64_ctrl
`default_nettype wire
